// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, FSM state type and the error decode.
package apb_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ID_ADDR = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_state_e;

  // Unmapped addresses and writes to the read-only ID register are errors.
  function automatic logic decode_err(input logic [ADDR_W-1:0] addr,
                                      input logic              write,
                                      input int unsigned       valid_depth);
    return (32'(addr) >= valid_depth) || (write && (addr == ID_ADDR));
  endfunction

endpackage

// File: rtl/apb_regs_slave_if.sv
// APB bus bundle between the team's master and a completer.
interface apb_regs_slave_if;
  import apb_pkg::*;

  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, paddr, pwdata, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwdata, pwrite,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile.sv
// Register storage: one write port, one combinational read port.
// Address 0 and addresses >= VALID_DEPTH hold nothing and read as zero.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned VALID_DEPTH = 12
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wstored;
  logic              w_rstored;

  assign w_wstored = (i_waddr != ID_ADDR) && (32'(i_waddr) < VALID_DEPTH);
  assign w_rstored = (i_raddr != ID_ADDR) && (32'(i_raddr) < VALID_DEPTH);
  assign o_rdata   = w_rstored ? r_mem[i_raddr] : '0;

  // Storage update; reset clears every entry.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && w_wstored) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/apb_regs_slave.sv
// APB completer: register file behind a fixed-wait-state transfer FSM.
module apb_regs_slave
  import apb_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter int unsigned       VALID_DEPTH = 12,
  parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_regs_slave_if.slave  apb
);

  apb_state_e        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_prdata, w_prdata_nxt;
  logic              r_pready, w_pready_nxt;
  logic              r_pslverr, w_pslverr_nxt;
  logic              w_latch;
  logic              w_commit;
  logic              w_err;
  logic [ADDR_W-1:0] w_s_addr;
  logic              w_s_write;
  logic              w_s_err;
  logic [DATA_W-1:0] w_s_rdata;
  logic [DATA_W-1:0] w_reg_rdata;

  // With zero wait states the response is sampled on the setup edge, before
  // the latches hold the transfer, so sampling looks at the live bus in IDLE.
  assign w_s_addr  = (r_state == IDLE) ? apb.paddr  : r_addr;
  assign w_s_write = (r_state == IDLE) ? apb.pwrite : r_write;
  assign w_s_err   = decode_err(w_s_addr, w_s_write, VALID_DEPTH);
  assign w_s_rdata = (w_s_write || w_s_err) ? '0 :
                     (w_s_addr == ID_ADDR)  ? ID_VALUE : w_reg_rdata;
  assign w_err     = decode_err(r_addr, r_write, VALID_DEPTH);

  apb_regfile #(.VALID_DEPTH(VALID_DEPTH)) u_regfile (
    .pclk    (pclk),
    .presetn (presetn),
    .i_we    (w_commit),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (w_s_addr),
    .o_rdata (w_reg_rdata)
  );

  // Next-state, wait counter and registered response values.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_prdata_nxt  = r_prdata;
    w_pready_nxt  = r_pready;
    w_pslverr_nxt = r_pslverr;
    w_latch       = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt   = READY;
            w_pready_nxt  = 1'b1;
            w_prdata_nxt  = w_s_rdata;
            w_pslverr_nxt = w_s_err;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!apb.psel) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_prdata_nxt  = '0;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else if (apb.penable) begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt   = READY;
            w_pready_nxt  = 1'b1;
            w_prdata_nxt  = w_s_rdata;
            w_pslverr_nxt = w_s_err;
          end
        end
      end
      READY: begin
        if (!apb.psel) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_prdata_nxt  = '0;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else if (apb.penable) begin
          w_commit      = r_write && !w_err;
          w_state_nxt   = IDLE;
          w_prdata_nxt  = '0;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
    end
  end

  // Setup-phase latches for address, direction and write data.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_addr  <= apb.paddr;
      r_write <= apb.pwrite;
      r_wdata <= apb.pwdata;
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_regs_slave.sv
// Bench for apb_regs_slave: a 2-wait-state and a 0-wait-state instance,
// directed scenarios followed by random transfers against a register model.
module tb_apb_regs_slave;
  import apb_pkg::*;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_regs_slave_if b2 ();
  apb_regs_slave_if b0 ();

  apb_regs_slave #(.WAIT_CYCLES(2), .VALID_DEPTH(12), .ID_VALUE(8'hA5)) u_dut2 (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (b2)
  );

  apb_regs_slave #(.WAIT_CYCLES(0), .VALID_DEPTH(12), .ID_VALUE(8'hA5)) u_dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (b0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] mem2 [16];
  logic [7:0] mem0 [16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit z, input logic sel, input logic en, input logic wr,
                       input logic [3:0] a, input logic [7:0] d);
    if (z) begin
      b0.psel = sel; b0.penable = en; b0.pwrite = wr; b0.paddr = a; b0.pwdata = d;
    end else begin
      b2.psel = sel; b2.penable = en; b2.pwrite = wr; b2.paddr = a; b2.pwdata = d;
    end
  endtask

  task automatic sample(input bit z, output logic rdy, output logic [7:0] rd, output logic er);
    if (z) begin rdy = b0.pready; rd = b0.prdata; er = b0.pslverr; end
    else   begin rdy = b2.pready; rd = b2.prdata; er = b2.pslverr; end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mem2[i] = 8'h00; mem0[i] = 8'h00; end
  endtask

  // One full transfer, called #1 after a rising edge; returns #1 after the
  // completing edge with the bus idle, so calls chain back-to-back.
  task automatic xfer(input bit z, input logic wr, input logic [3:0] a,
                      input logic [7:0] d, input string tag);
    int         w;
    logic       rdy, er, exp_er;
    logic [7:0] rd, exp_rd;
    w      = z ? 0 : 2;
    exp_er = (a >= 4'd12) || (wr && a == 4'd0);
    exp_rd = (wr || exp_er) ? 8'h00 : (a == 4'd0) ? 8'hA5 : (z ? mem0[a] : mem2[a]);
    drive(z, 1'b1, 1'b0, wr, a, d);
    @(posedge pclk); #1;
    drive(z, 1'b1, 1'b1, wr, a, d);
    for (int k = 1; k <= w + 1; k++) begin
      sample(z, rdy, rd, er);
      chk($sformatf("%s pready_A%0d", tag, k), 8'(rdy), (k == w + 1) ? 8'd1 : 8'd0);
      if (k <= w) begin @(posedge pclk); #1; end
    end
    chk($sformatf("%s pslverr", tag), 8'(er), 8'(exp_er));
    if (!wr) chk($sformatf("%s prdata", tag), rd, exp_rd);
    @(posedge pclk); #1;
    if (wr && !exp_er) begin
      if (z) mem0[a] = d; else mem2[a] = d;
    end
    drive(z, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    sample(z, rdy, rd, er);
    chk($sformatf("%s pready_after", tag), 8'(rdy), 8'd0);
    chk($sformatf("%s prdata_after", tag), rd, 8'h00);
  endtask

  initial begin
    logic       rdy, er, rwr;
    logic [7:0] rd, rdat;
    logic [3:0] radr;
    bit         rz;

    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    #12;
    sample(1'b0, rdy, rd, er);
    chk("reset pready", 8'(rdy), 8'd0);
    chk("reset prdata", rd, 8'h00);
    chk("reset pslverr", 8'(er), 8'd0);
    #10 presetn = 1'b1;
    @(posedge pclk); #1;

    // ID read, write/read back-to-back, error cases.
    xfer(1'b0, 1'b0, 4'h0, 8'h00, "id_read");
    xfer(1'b0, 1'b1, 4'h5, 8'h3C, "wr5");
    xfer(1'b0, 1'b0, 4'h5, 8'h00, "rd5");
    xfer(1'b0, 1'b1, 4'h0, 8'hFF, "wr_id_err");
    xfer(1'b0, 1'b0, 4'h0, 8'h00, "id_reread");
    xfer(1'b0, 1'b0, 4'hD, 8'h00, "rd13_err");

    // Abort: psel dropped during WAIT of a write.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 8'h77);
    @(posedge pclk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 8'h77);
    @(posedge pclk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      sample(1'b0, rdy, rd, er);
      chk($sformatf("abort pready_%0d", k), 8'(rdy), 8'd0);
      @(posedge pclk); #1;
    end
    xfer(1'b0, 1'b0, 4'h2, 8'h00, "rd2_after_abort");

    // Reset pulsed mid-WAIT of a write.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'h11);
    @(posedge pclk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 8'h11);
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    sample(1'b0, rdy, rd, er);
    chk("rst_wait pready", 8'(rdy), 8'd0);
    chk("rst_wait prdata", rd, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    model_reset();
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 1'b0, 4'h3, 8'h00, "rd3_after_rst");
    xfer(1'b0, 1'b0, 4'h5, 8'h00, "rd5_after_rst");

    // Reset while pready is high clears outputs without waiting for a clock.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge pclk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    sample(1'b0, rdy, rd, er);
    chk("rst_ready pready_before", 8'(rdy), 8'd1);
    chk("rst_ready prdata_before", rd, 8'hA5);
    presetn = 1'b0;
    #1;
    sample(1'b0, rdy, rd, er);
    chk("rst_ready pready_async", 8'(rdy), 8'd0);
    chk("rst_ready prdata_async", rd, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    // penable without a setup phase is ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      sample(1'b0, rdy, rd, er);
      chk($sformatf("proto pready_%0d", k), 8'(rdy), 8'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge pclk); #1;

    // Zero-wait instance.
    xfer(1'b1, 1'b1, 4'h7, 8'h5A, "w0_wr7");
    xfer(1'b1, 1'b0, 4'h7, 8'h00, "w0_rd7");
    xfer(1'b1, 1'b0, 4'h0, 8'h00, "w0_id");
    xfer(1'b1, 1'b0, 4'hC, 8'h00, "w0_rd12_err");

    // Random traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      rz   = bit'($urandom_range(0, 1));
      rwr  = logic'($urandom_range(0, 1));
      radr = 4'($urandom_range(0, 15));
      rdat = 8'($urandom);
      xfer(rz, rwr, radr, rdat, $sformatf("rnd%0d", i));
    end
    for (int a = 0; a < 16; a++) begin
      xfer(1'b0, 1'b0, 4'(a), 8'h00, $sformatf("sweep2_%0d", a));
      xfer(1'b1, 1'b0, 4'(a), 8'h00, $sformatf("sweep0_%0d", a));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
